// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the refill port arbiter: requester count, index
// width, FSM state encoding and a one-hot helper.
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // One-hot vector with bit <id> set.
    function automatic logic [NUM_REQ-1:0] onehot_of(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/arb_prio_enc8.sv
// ---------------------------------------------------------------------------
// arb_prio_enc8
// Combinational 8-to-3 priority encoder, highest set index wins.
//
// Ports:
//   req  in   8  request vector (bit 7 highest priority)
//   idx  out  3  index of the highest set bit; 0 when none set
//   any  out  1  at least one bit of req is set
// ---------------------------------------------------------------------------
module arb_prio_enc8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        idx = '0;
        any = |req;
        // Ascending scan: the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/refill_port_arbiter.sv
// ---------------------------------------------------------------------------
// refill_port_arbiter
// Grants ownership of a shared refill port to one of eight requesters.
// A grant is held until the owner pulses done, drops its request, or the
// hold counter reaches HOLD_MAX cycles (forced release, timeout pulse).
// Every release is followed by at least one idle cycle.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> rotating priority; the last winner
//                                    becomes lowest priority next time
//                       undefined -> fixed priority, req[7] highest
//
// Parameters:
//   HOLD_MAX  maximum cycles a grant is held (1..255)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  level requests, held until granted
//   done       in   1  owner transfer complete, single-cycle pulse
//   gnt        out  8  registered one-hot grant, zero when no owner
//   gnt_id     out  3  binary index of the owner, 0 when none
//   gnt_valid  out  1  a grant is active
//   timeout    out  1  one-cycle pulse on a hold-counter release
// ---------------------------------------------------------------------------
module refill_port_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               gnt_valid_d;
    logic               timeout_d;

    logic [NUM_REQ-1:0] req_rot;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_any;
    logic [ID_W-1:0]    winner;

    // -----------------------------------------------------------------------
    // Arbitration: the encoder always sees "highest index wins"; round robin
    // rotates the request vector so the last winner sits at position 0.
    // -----------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Position j holds req[(j + ptr) mod 8]; position 7 is ptr-1, the new
    // highest priority, and position 0 is ptr itself, the lowest.
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            req_rot[j] = req[ID_W'(j) + ptr_q];
        end
    end

    assign winner = enc_idx + ptr_q;
`else
    assign req_rot = req;
    assign winner  = enc_idx;
`endif

    arb_prio_enc8 u_enc (
        .req (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    // -----------------------------------------------------------------------
    // Next-state and output decision
    // -----------------------------------------------------------------------
    logic owner_req;
    logic at_limit;

    assign owner_req = |(req & gnt);
    assign at_limit  = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    gnt_d       = onehot_of(winner);
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d       = winner;
`endif
                end
            end
            ST_BUSY: begin
                if (done || !owner_req || at_limit) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    // Only a pure hold-limit release is a timeout; done and
                    // abandon take precedence.
                    timeout_d   = at_limit && !done && owner_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_refill_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_refill_port_arbiter
// Directed scenarios followed by randomized traffic. A reference model
// tracks the owner and the cycle of its grant, and pushes the expected
// outputs after every rising edge; a monitor pops and compares on the
// falling edge. Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_refill_port_arbiter;

    localparam int HOLD_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    refill_port_arbiter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   owner    = -1;   // current owner index, -1 when the port is free
    int   cyc      = 0;    // rising edges seen since reset release
    int   gnt_cyc  = 0;    // edge on which the current owner was granted
    int   last_win = 0;    // most recent winner (rotating priority anchor)
    bit   model_to = 1'b0;

    function automatic int pick(input logic [7:0] r);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last_win - k + 8) % 8;
            if (r[i]) return i;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            owner    = -1;
            cyc      = 0;
            gnt_cyc  = 0;
            last_win = 0;
            model_to = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            model_to = 1'b0;
            if (owner < 0) begin
                if (req != 8'h00) begin
                    owner    = pick(req);
                    gnt_cyc  = cyc;
                    last_win = owner;
                end
            end else if (done) begin
                owner = -1;
            end else if (!req[owner]) begin
                owner = -1;
            end else if (cyc - gnt_cyc == HOLD_MAX) begin
                // The grant has now been held for HOLD_MAX busy edges.
                owner    = -1;
                model_to = 1'b1;
            end
        end
        e.gnt   = (owner >= 0) ? (8'b1 << owner) : 8'h00;
        e.id    = (owner >= 0) ? 3'(owner) : 3'd0;
        e.valid = (owner >= 0);
        e.to    = model_to;
        exp_q.push_back(e);
    end

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_gnt",       32'(gnt),       32'(e.gnt));
            check("sb_gnt_id",    32'(gnt_id),    32'(e.id));
            check("sb_gnt_valid", 32'(gnt_valid), 32'(e.valid));
            check("sb_timeout",   32'(timeout),   32'(e.to));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (3) tick();
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic grant and done release.
        req = 8'h24;
        tick();
        check("t29_gnt",    32'(gnt),       32'h20);
        check("t29_gnt_id", 32'(gnt_id),    32'd5);
        check("t29_valid",  32'(gnt_valid), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        check("t29_release", 32'(gnt), 32'h0);
        tick();

        // Owner abandons with a lower requester pending.
        req = 8'h0A;
        tick();
        check("t34_gnt", 32'(gnt), 32'h08);
        repeat (2) tick();
        req = 8'h02;
        tick();
        check("t34_idle", 32'(gnt), 32'h0);
        tick();
        check("t34_next", 32'(gnt), 32'h02);
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        // Hold limit forces release with a timeout pulse.
        req = 8'h08;
        tick();
        check("t30_gnt", 32'(gnt), 32'h08);
        repeat (HOLD_MAX - 1) tick();
        check("t30_still", 32'(gnt),     32'h08);
        check("t30_no_to", 32'(timeout), 32'h0);
        tick();
        check("t30_rel", 32'(gnt),     32'h0);
        check("t30_to",  32'(timeout), 32'h1);
        req = 8'h00;
        tick();
        check("t30_to_end", 32'(timeout), 32'h0);
        tick();

        // done coinciding with the hold limit is a normal release.
        req = 8'h08;
        tick();
        repeat (HOLD_MAX - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        check("t31_rel", 32'(gnt),     32'h0);
        check("t31_to",  32'(timeout), 32'h0);
        tick();

        // Fresh reset, then grant order under constant full requests.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check("t32_order", 32'(gnt_id), 32'((7 - k + 8) % 8));
`else
            check("t32_order", 32'(gnt_id), 32'd7);
`endif
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
        end
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        // Asynchronous reset in the middle of a grant.
        req = 8'h02;
        tick();
        check("t33_gnt", 32'(gnt), 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("t33_async_gnt",   32'(gnt),       32'h0);
        check("t33_async_id",    32'(gnt_id),    32'h0);
        check("t33_async_valid", 32'(gnt_valid), 32'h0);
        check("t33_async_to",    32'(timeout),   32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t33_regrant", 32'(gnt), 32'h02);
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        // Randomized traffic: sticky request bits, sparse done pulses and
        // occasional mid-cycle resets.
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(0, 7) == 0);
            if (n % 700 == 350) begin
                #3;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        req  = 8'h00;
        done = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
